regfile_write_arbiter: RTL

Sequencer and arbiter for the 32×32 general register file's single write port. Shares the port between the core writeback path and a host/debug loader with a bounded-starvation policy. Also runs a 32-cycle clear sequence on command. Sits between writeback/host logic and the register file's `rdIn`/`DataIn`/`WriteIn` inputs.

---
 rtl/regfile_write_arbiter_pkg.sv | 24 ++
 rtl/regfile_write_arbiter_starve_counter.sv | 56 +++++
 rtl/regfile_write_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared definitions for the register-file write-port arbiter:
//   - default register-file geometry (NREG/AW/DW), also used by the register file
//   - default host starvation bound and the width of the starvation counter
//   - arbiter state encoding (RUN, CLEAR)
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

  localparam int RF_NREG          = 32;
  localparam int RF_AW            = 5;
  localparam int RF_DW            = 32;
  localparam int RF_HOST_MAX_WAIT = 4;

  // Counter is 4 bits wide, so the host bound may be 1..15.
  localparam int STARVE_W = 4;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
// Saturating up-counter tracking how many consecutive cycles the host has been
// refused the write port. Clear has priority over increment; the count stops at
// MAX and o_max flags that the host must be given the next slot.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_clr    clear the count to zero
//   i_inc    increment the count (saturating at MAX)
//   o_max    count has reached MAX
// -----------------------------------------------------------------------------
module starve_counter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int MAX = RF_HOST_MAX_WAIT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_max
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

  logic [STARVE_W-1:0] r_count;
  logic [STARVE_W-1:0] w_count_nxt;
  logic                w_at_max;

  assign w_at_max = (r_count >= MAX_V);

  // Next count: clear wins, otherwise count up until the bound is reached.
  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = {STARVE_W{1'b0}};
    end else if (i_inc && !w_at_max) begin
      w_count_nxt = r_count + STARVE_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {STARVE_W{1'b0}};
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_max = w_at_max;

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the single write port of the general register file. In RUN it arbitrates
// between the core writeback path (no handshake, holds while stalled) and a
// host/debug loader (valid/ready), guaranteeing the host a slot after
// HOST_MAX_WAIT consecutive refused cycles. In CLEAR it walks every register
// (including R0) writing zero, one per cycle. Grants are combinational; the
// resulting write is registered, so it reaches the register file one cycle later.
// Ports:
//   clkIn, resetIn                   clock / async active-low reset
//   wbWriteIn, wbRdIn, wbDataIn      writeback request, destination, data
//   wbStallOut                       writeback refused this cycle
//   hostValidIn, hostRdIn, hostDataIn, hostReadyOut   host request/handshake
//   clearReqIn                       one-cycle pulse: start the clear walk
//   busyOut                          clear walk in progress
//   rdOut, DataOut, WriteOut         registered register-file write port
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREG          = RF_NREG,
  parameter int AW            = RF_AW,
  parameter int DW            = RF_DW,
  parameter int HOST_MAX_WAIT = RF_HOST_MAX_WAIT
) (
  input  logic          clkIn,
  input  logic          resetIn,
  input  logic          wbWriteIn,
  input  logic [AW-1:0] wbRdIn,
  input  logic [DW-1:0] wbDataIn,
  output logic          wbStallOut,
  input  logic          hostValidIn,
  input  logic [AW-1:0] hostRdIn,
  input  logic [DW-1:0] hostDataIn,
  output logic          hostReadyOut,
  input  logic          clearReqIn,
  output logic          busyOut,
  output logic [AW-1:0] rdOut,
  output logic [DW-1:0] DataOut,
  output logic          WriteOut
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;

  logic          w_forced;
  logic          w_host_ready;
  logic          w_wb_stall;
  logic          w_grant_host;
  logic          w_grant_wb;
  logic          w_issue;
  logic [AW-1:0] w_issue_rd;
  logic [DW-1:0] w_issue_data;
  logic          w_starve_inc;

  logic          r_write;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_data;

  // The host is "blocked" whenever it asks and is refused, including during
  // CLEAR, so a host waiting through a clear is served first afterwards.
  assign w_starve_inc = hostValidIn && !w_host_ready;

  starve_counter #(
    .MAX (HOST_MAX_WAIT)
  ) u_starve (
    .i_clk   (clkIn),
    .i_rst_n (resetIn),
    .i_clr   (!w_starve_inc),
    .i_inc   (w_starve_inc),
    .o_max   (w_forced)
  );

  // Handshakes, grant selection and next state/index.
  always_comb begin
    w_host_ready = 1'b0;
    w_wb_stall   = 1'b0;
    w_grant_host = 1'b0;
    w_grant_wb   = 1'b0;
    w_issue      = 1'b0;
    w_issue_rd   = r_rd;
    w_issue_data = r_data;
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    case (r_state)
      ST_RUN: begin
        w_host_ready = !wbWriteIn || w_forced;
        // Writeback only yields when the host is both forced and asking.
        w_wb_stall   = wbWriteIn && w_forced && hostValidIn;
        w_grant_host = hostValidIn && w_host_ready;
        w_grant_wb   = wbWriteIn && !w_wb_stall;
        // R0 is hardwired: the transfer completes but no write is issued.
        if (w_grant_host) begin
          w_issue      = (hostRdIn != {AW{1'b0}});
          w_issue_rd   = hostRdIn;
          w_issue_data = hostDataIn;
        end else if (w_grant_wb) begin
          w_issue      = (wbRdIn != {AW{1'b0}});
          w_issue_rd   = wbRdIn;
          w_issue_data = wbDataIn;
        end else begin
          w_issue      = 1'b0;
        end
        if (clearReqIn) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_RUN;
        end
        w_idx_nxt = {AW{1'b0}};
      end
      ST_CLEAR: begin
        w_host_ready = 1'b0;
        w_wb_stall   = wbWriteIn;
        // Clear writes every index, R0 included.
        w_issue      = 1'b1;
        w_issue_rd   = r_idx;
        w_issue_data = {DW{1'b0}};
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = {AW{1'b0}};
        end else begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = r_idx + AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_idx_nxt   = {AW{1'b0}};
      end
    endcase
  end

  // State and clear-walk index.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      r_state <= ST_RUN;
      r_idx   <= {AW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      r_write <= 1'b0;
      r_rd    <= {AW{1'b0}};
      r_data  <= {DW{1'b0}};
    end else begin
      r_write <= w_issue;
      if (w_issue) begin
        r_rd   <= w_issue_rd;
        r_data <= w_issue_data;
      end
    end
  end

  assign WriteOut     = r_write;
  assign rdOut        = r_rd;
  assign DataOut      = r_data;
  assign busyOut      = (r_state == ST_CLEAR);
  assign hostReadyOut = w_host_ready;
  assign wbStallOut   = w_wb_stall;

endmodule
